// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter: code conversion, terminal values, direction encoding.
// Functions work on a zero-extended MAX_W vector so any WIDTH up to MAX_W can use them.
package gray_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Terminal count for up-counting (all ones in the low w bits) and down-counting (zero).
    function automatic logic [MAX_W-1:0] tc_up_val(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] tc_dn_val();
        return '0;
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder, WIDTH bits.
module gray_encode
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    logic [MAX_W-1:0] w_gray_full;

    assign w_gray_full = bin2gray(MAX_W'(i_bin));
    assign o_gray      = w_gray_full[WIDTH-1:0];

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray output and a valid/ready output stage.
// The Gray code is encoded from the next-state binary value so both registers update together.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             tc
);

    localparam logic [MAX_W-1:0] TC_UP_FULL = tc_up_val(WIDTH);
    localparam logic [MAX_W-1:0] TC_DN_FULL = tc_dn_val();
    localparam logic [WIDTH-1:0] TC_UP      = TC_UP_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TC_DN      = TC_DN_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_vld;

    dir_e             w_dir;
    logic             w_stall;
    logic             w_accept;
    logic             w_tc;
    logic             w_step;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_vld_nxt;

    assign w_dir    = dir_e'(up_dn);
    assign w_stall  = r_vld & ~out_ready;
    assign w_accept = r_vld & out_ready;
    assign w_tc     = (w_dir == DIR_UP) ? (r_bin == TC_UP) : (r_bin == TC_DN);

    // Saturating mode suppresses the step at terminal count, leaving only the accept handshake.
    assign w_step   = en & ~w_stall & ~(w_tc & ~WRAP);

    always_comb begin
        w_bin_nxt = r_bin;
        w_vld_nxt = r_vld & ~w_accept;
        if (load) begin
            w_bin_nxt = load_val;
            w_vld_nxt = 1'b1;
        end else if (w_step) begin
            w_bin_nxt = (w_dir == DIR_UP) ? r_bin + ONE : r_bin - ONE;
            w_vld_nxt = 1'b1;
        end
    end

    gray_encode #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_bin  (w_bin_nxt),
        .o_gray (w_gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_vld  <= w_vld_nxt;
        end
    end

    assign bin_o     = r_bin;
    assign gray_o    = r_gray;
    assign out_valid = r_vld;
    assign tc        = w_tc;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter (WIDTH=3): one wrapping and one saturating instance share stimulus
// and are compared every cycle against an integer-arithmetic model, plus directed literal checks.
module tb_gray_code_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, up_dn, load, out_ready;
    logic [2:0] load_val;

    logic       vld_w, tc_w, vld_s, tc_s;
    logic [2:0] bin_w, gray_w, bin_s, gray_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(3), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out_ready(out_ready), .out_valid(vld_w), .bin_o(bin_w), .gray_o(gray_w), .tc(tc_w)
    );

    gray_code_counter #(.WIDTH(3), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .out_ready(out_ready), .out_valid(vld_s), .bin_o(bin_s), .gray_o(gray_s), .tc(tc_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = wrapping instance, 1 = saturating instance.
    int   m_bin [2];
    bit   m_vld [2];
    bit   m_has_prev [2];
    int   m_prev_g [2];
    bit   started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit acc, stall, at_tc;
            acc   = m_vld[k] && out_ready;
            stall = m_vld[k] && !out_ready;
            at_tc = up_dn ? (m_bin[k] == 7) : (m_bin[k] == 0);
            if (!rst_n) begin
                m_bin[k] = 0;
                m_vld[k] = 0;
                m_has_prev[k] = 0;
            end else if (load) begin
                m_bin[k] = load_val;
                m_vld[k] = 1;
                m_has_prev[k] = 0;
            end else if (en && !stall && !(k == 1 && at_tc)) begin
                m_bin[k] = (m_bin[k] + (up_dn ? 1 : 7)) % 8;
                m_vld[k] = 1;
            end else if (acc) begin
                m_vld[k] = 0;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                int ab, ag, av, at, eg, et;
                ab = (k == 0) ? int'(bin_w)  : int'(bin_s);
                ag = (k == 0) ? int'(gray_w) : int'(gray_s);
                av = (k == 0) ? int'(vld_w)  : int'(vld_s);
                at = (k == 0) ? int'(tc_w)   : int'(tc_s);
                eg = m_bin[k] ^ (m_bin[k] >> 1);
                et = up_dn ? int'(m_bin[k] == 7) : int'(m_bin[k] == 0);
                chk(k == 0 ? "wrap.bin"  : "sat.bin",  ab, m_bin[k]);
                chk(k == 0 ? "wrap.gray" : "sat.gray", ag, eg);
                chk(k == 0 ? "wrap.vld"  : "sat.vld",  av, int'(m_vld[k]));
                chk(k == 0 ? "wrap.tc"   : "sat.tc",   at, et);
                if (av == 1 && out_ready === 1'b1) begin
                    if (m_has_prev[k])
                        chk(k == 0 ? "wrap.hamming" : "sat.hamming", $countones(ag ^ m_prev_g[k]), 1);
                    m_prev_g[k]   = ag;
                    m_has_prev[k] = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int gseq [8] = '{1, 3, 2, 6, 7, 5, 4, 0};

    // Trailing directed vectors: {en, up_dn, load, load_val, out_ready}
    typedef struct { bit e; bit u; bit l; int lv; bit r; } vec_t;
    vec_t vecs [10] = '{
        '{1, 1, 1, 6, 1}, '{1, 1, 0, 0, 1}, '{1, 1, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 1},
        '{1, 0, 0, 0, 1}, '{0, 0, 0, 0, 1}, '{0, 1, 0, 0, 1}, '{1, 1, 1, 7, 1}, '{1, 1, 0, 0, 1}
    };

    initial begin
        rst_n = 0; en = 1; up_dn = 1; load = 1; load_val = 3'd5; out_ready = 1;

        // Reset overrides en and load
        tick(); tick();
        chk("rst.bin", bin_w, 0);
        chk("rst.gray", gray_w, 0);
        chk("rst.vld", vld_w, 0);
        chk("rst.sat_vld", vld_s, 0);

        // Up count through a full wrap
        rst_n = 1; load = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("up.gray", gray_w, gseq[i]);
            chk("up.vld", vld_w, 1);
            if (i == 6) chk("up.tc", tc_w, 1);
        end
        chk("sat.hold7", bin_s, 7);
        chk("sat.vld_drop", vld_s, 0);

        // Stall at gray 011
        tick(); tick();
        chk("pre_stall.gray", gray_w, 3);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.bin", bin_w, 2);
            chk("stall.gray", gray_w, 3);
            chk("stall.vld", vld_w, 1);
        end
        out_ready = 1;
        tick();
        chk("release.gray", gray_w, 2);

        // Down count from zero
        load = 1; load_val = 3'd0;
        tick();
        load = 0; up_dn = 0;
        tick();
        chk("dn_wrap.bin", bin_w, 7);
        chk("dn_wrap.gray", gray_w, 4);
        chk("dn_sat.bin", bin_s, 0);
        chk("dn_sat.tc", tc_s, 1);
        chk("dn_sat.vld", vld_s, 0);

        // Load wins over step while stalled
        out_ready = 0; load = 1; load_val = 3'd5;
        tick();
        chk("load.bin", bin_w, 5);
        chk("load.gray", gray_w, 7);
        chk("load.vld", vld_w, 1);

        // Reset during a stall at 110
        load_val = 3'd6;
        tick();
        load = 0;
        tick();
        chk("stall6.bin", bin_w, 6);
        rst_n = 0;
        tick();
        chk("rst_stall.bin", bin_w, 0);
        chk("rst_stall.gray", gray_w, 0);
        chk("rst_stall.vld", vld_w, 0);
        rst_n = 1; up_dn = 1; en = 1; out_ready = 1;
        tick();
        chk("post_rst.gray", gray_w, 1);

        foreach (vecs[i]) begin
            en = vecs[i].e; up_dn = vecs[i].u; load = vecs[i].l;
            load_val = 3'(vecs[i].lv); out_ready = vecs[i].r;
            tick();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
